// File: rtl/op_scheduler.sv
// op_scheduler: round-robin arbiter sharing one serial output line.
// Optional one-tick gap between transfers: define OP_SCHED_GAP_EN.
module op_scheduler #(
   parameter int NREQ  = 4,
   parameter int PAT_W = 8,
   parameter int DIV_W = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*PAT_W-1:0] pat,
   input  logic [DIV_W-1:0]      div,
   output logic [NREQ-1:0]       grant,
   output logic                  busy,
   output logic                  done,
   output logic                  op
);

   localparam int LW = $clog2(NREQ);
   localparam int BW = $clog2(PAT_W);

`ifdef OP_SCHED_GAP_EN
   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      GAP
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE,
      SHIFT
   } state_t;
`endif

   state_t           state;
   logic [LW-1:0]    last;
   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] dv;
   logic [BW-1:0]    bcnt;
   logic [PAT_W-1:0] sh;

   logic [LW-1:0]    win;
   logic [LW-1:0]    idx;
   logic             found;
   logic [PAT_W-1:0] wpat;
   logic [NREQ-1:0]  wgnt;

   // round-robin search starting just after the previous winner
   always_comb begin
      win   = last;
      idx   = last;
      found = 1'b0;
      for (int i = 1; i <= NREQ; i++) begin
         idx = last + LW'(i);
         if (!found && req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
   end

   // select the winner's pattern slice
   always_comb begin
      wpat = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win == LW'(i))
            wpat = pat[i*PAT_W +: PAT_W];
      end
   end

   assign wgnt = NREQ'(1) << win;

   // sequencer: arbitration, prescaling and shifting with registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         last  <= LW'(NREQ-1);
         cnt   <= '0;
         bcnt  <= '0;
         dv    <= DIV_W'(1);
         sh    <= '0;
         grant <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         op    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (|req) begin
                  state <= SHIFT;
                  last  <= win;
                  grant <= wgnt;
                  busy  <= 1'b1;
                  op    <= wpat[PAT_W-1];
                  sh    <= wpat;
                  dv    <= (div == '0) ? DIV_W'(1) : div;
                  cnt   <= '0;
                  bcnt  <= '0;
               end
            end
            SHIFT: begin
               if (cnt == dv - DIV_W'(1)) begin
                  cnt  <= '0;
                  sh   <= sh << 1;
                  op   <= sh[PAT_W-2];
                  bcnt <= bcnt + BW'(1);
                  if (bcnt == BW'(PAT_W-1)) begin
                     grant <= '0;
                     busy  <= 1'b0;
                     op    <= 1'b0;
                     done  <= 1'b1;
                     bcnt  <= '0;
`ifdef OP_SCHED_GAP_EN
                     state <= GAP;
`else
                     state <= IDLE;
`endif
                  end
               end else begin
                  cnt <= cnt + DIV_W'(1);
               end
            end
`ifdef OP_SCHED_GAP_EN
            GAP: begin
               if (cnt == dv - DIV_W'(1)) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + DIV_W'(1);
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_op_scheduler.sv
// tb_op_scheduler: scoreboard bench for the round-robin serial scheduler.
// Stimulus queues expected transfers; a negedge monitor checks them.
`timescale 1ns/1ps
module tb_op_scheduler;

   typedef struct {
      logic [3:0] g;
      logic [7:0] p;
      int         d;
   } exp_t;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  req   = '0;
   logic [31:0] pat   = '0;
   logic [15:0] div   = 16'd1;
   logic [3:0]  grant;
   logic        busy;
   logic        done;
   logic        op;

   exp_t sb[$];
   exp_t cur;
   int   n_chk    = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   done_cyc = 0;
   int   last_gap = 0;
   int   n_start  = 0;
   int   ncyc     = 0;
   int   base     = 0;
   bit   active   = 1'b0;

   op_scheduler #(
      .NREQ (4),
      .PAT_W(8),
      .DIV_W(16)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .req  (req),
      .pat  (pat),
      .div  (div),
      .grant(grant),
      .busy (busy),
      .done (done),
      .op   (op)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic push(input logic [3:0] g, input logic [7:0] p, input int d);
      exp_t e;
      e.g = g;
      e.p = p;
      e.d = (d == 0) ? 1 : d;
      sb.push_back(e);
   endtask

   function automatic int exp_gap(input int d);
`ifdef OP_SCHED_GAP_EN
      return d + 1;
`else
      return 1 + 0 * d;
`endif
   endfunction

   task automatic wait_start(input int target);
      bit ok = 1'b0;
      for (int i = 0; i < 1000 && !ok; i++) begin
         @(negedge clk);
         #1;
         if (n_start >= target) ok = 1'b1;
      end
      if (!ok) chk("timeout_start", 32'(n_start), 32'(target));
   endtask

   task automatic wait_quiet();
      bit ok = 1'b0;
      for (int i = 0; i < 1000 && !ok; i++) begin
         @(negedge clk);
         #1;
         if (sb.size() == 0 && !active && !busy) ok = 1'b1;
      end
      if (!ok) chk("timeout_quiet", 32'(sb.size()), 0);
      repeat (3) @(negedge clk);
      #1;
   endtask

   // monitor: pops expected transfers and checks every output cycle
   always @(negedge clk) begin
      if (reset) begin
         active = 1'b0;
      end else begin
         cyc++;
         chk("onehot0", 32'($onehot0(grant)), 1);
         if (busy && !active) begin
            active   = 1'b1;
            ncyc     = 0;
            n_start++;
            last_gap = cyc - done_cyc;
            if (sb.size() == 0) begin
               chk("sb_underflow", 1, 0);
               cur.g = grant;
               cur.p = '0;
               cur.d = 1;
            end else begin
               cur = sb.pop_front();
            end
            chk("grant", 32'(grant), 32'(cur.g));
         end
         if (active) begin
            if (busy) begin
               chk("grant_hold", 32'(grant), 32'(cur.g));
               if (ncyc / cur.d < 8)
                  chk("op_bit", 32'(op), 32'(cur.p[7 - ncyc / cur.d]));
               else
                  chk("busy_long", 32'(ncyc), 32'(8 * cur.d));
               ncyc++;
            end else begin
               chk("done_pulse", 32'(done), 1);
               chk("busy_len", 32'(ncyc), 32'(8 * cur.d));
               chk("end_grant", 32'(grant), 0);
               chk("end_op", 32'(op), 0);
               active   = 1'b0;
               done_cyc = cyc;
            end
         end else begin
            chk("idle_done", 32'(done), 0);
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_grant", 32'(grant), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_op", 32'(op), 0);
      #1 reset = 1'b0;
      repeat (2) @(negedge clk);
      #1;

      // round-robin with all four requesting
      div = 16'd1;
      pat = {8'hC3, 8'h5A, 8'h96, 8'h2D};
      push(4'b0001, 8'h2D, 1);
      push(4'b0010, 8'h96, 1);
      push(4'b0100, 8'h5A, 1);
      push(4'b1000, 8'hC3, 1);
      push(4'b0001, 8'h2D, 1);
      base = n_start;
      req  = 4'b1111;
      wait_start(base + 1);
      for (int k = 2; k <= 5; k++) begin
         wait_start(base + k);
         chk("rr_gap", 32'(last_gap), 32'(exp_gap(1)));
      end
      req = '0;
      wait_quiet();

      // single transfer, arbitration latency
      pat = {24'h0, 8'hA5};
      push(4'b0001, 8'hA5, 1);
      chk("lat_before", 32'(grant), 0);
      req = 4'b0001;
      @(negedge clk);
      #1;
      chk("lat_grant", 32'(grant), 1);
      chk("lat_busy", 32'(busy), 1);
      chk("lat_op_msb", 32'(op), 1);
      req = '0;
      wait_quiet();

      // lone requester is re-granted
      pat = {16'h0, 8'h3C, 8'h0};
      push(4'b0010, 8'h3C, 1);
      push(4'b0010, 8'h3C, 1);
      base = n_start;
      req  = 4'b0010;
      wait_start(base + 1);
      wait_start(base + 2);
      chk("regrant_gap", 32'(last_gap), 32'(exp_gap(1)));
      req = '0;
      wait_quiet();

      // divisor 3, inputs changed mid-transfer
      div = 16'd3;
      pat = {24'h0, 8'hF0};
      push(4'b0001, 8'hF0, 3);
      base = n_start;
      req  = 4'b0001;
      wait_start(base + 1);
      div = 16'd5;
      pat = '0;
      req = '0;
      wait_quiet();

      // divisor 0 behaves as 1
      div = 16'd0;
      pat = {24'h0, 8'hA5};
      push(4'b0001, 8'hA5, 0);
      base = n_start;
      req  = 4'b0001;
      wait_start(base + 1);
      req = '0;
      wait_quiet();

      // asynchronous reset during bit 4
      div = 16'd2;
      pat = {24'h0, 8'hFF};
      push(4'b0001, 8'hFF, 2);
      base = n_start;
      req  = 4'b0001;
      wait_start(base + 1);
      req = '0;
      repeat (8) @(negedge clk);
      #2;
      chk("pre_rst_busy", 32'(busy), 1);
      reset = 1'b1;
      #1;
      chk("arst_grant", 32'(grant), 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_done", 32'(done), 0);
      chk("arst_op", 32'(op), 0);
      repeat (2) @(negedge clk);
      #1 reset = 1'b0;
      div = 16'd1;
      pat = {8'h0, 8'h7E, 8'h0, 8'h81};
      push(4'b0001, 8'h81, 1);
      push(4'b0100, 8'h7E, 1);
      base = n_start;
      req  = 4'b0101;
      wait_start(base + 1);
      wait_start(base + 2);
      chk("post_rst_gap", 32'(last_gap), 32'(exp_gap(1)));
      req = '0;
      wait_quiet();

      // two requesters, divisor 2: inter-transfer spacing
      div = 16'd2;
      pat = {16'h0, 8'h39, 8'hC6};
      push(4'b0001, 8'hC6, 2);
      push(4'b0010, 8'h39, 2);
      base = n_start;
      req  = 4'b0011;
      wait_start(base + 1);
      wait_start(base + 2);
      chk("gap_spacing", 32'(last_gap), 32'(exp_gap(2)));
      req = '0;
      wait_quiet();

      chk("sb_drained", 32'(sb.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
